// File: rtl/writeback_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_queue_pkg
// Description : Shared CPU backend types. Defines the write-back entry carried
//               from the functional units to the register-file write port.
//               Data width, GPR count and predicate count come from the
//               DATA_WIDTH / NUM_REG / NUM_PS macros (defaulted below).
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef NUM_REG
`define NUM_REG 32
`endif
`ifndef NUM_PS
`define NUM_PS 8
`endif

package writeback_queue_pkg;

    localparam int c_DATA_W = `DATA_WIDTH;
    localparam int c_RW_AW  = $clog2(`NUM_REG);
    localparam int c_PS_AW  = $clog2(`NUM_PS);

    typedef struct packed {
        logic                use_rw;
        logic [c_RW_AW-1:0]  rw_addr;
        logic [c_DATA_W-1:0] rw_data;
        logic                ps_write;
        logic [c_PS_AW-1:0]  ps_addr;
        logic                ps_data;
    } wb_entry_t;

    // A result that writes neither a GPR nor a predicate carries no work.
    function automatic logic wb_has_work(input logic use_rw, input logic ps_write);
        return use_rw | ps_write;
    endfunction

endpackage : writeback_queue_pkg

`default_nettype wire

// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : writeback_queue
// Description : Circular write-back buffer between two execution units and
//               the single register-file write port. Up to two enqueues and
//               one dequeue per cycle; fu0 is ordered ahead of fu1.
// Ports       : clk, rst (async, active-high), flush (sync clear)
//               fuN_valid/fuN_ready + result fields  (N = 0, 1) producers
//               write_valid + head fields                register-file port
//               count                                    current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_queue
    import writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,

    input  logic                       fu0_valid,
    output logic                       fu0_ready,
    input  logic                       fu0_use_rw,
    input  logic [c_RW_AW-1:0]         fu0_rw_addr,
    input  logic [c_DATA_W-1:0]        fu0_rw_data,
    input  logic                       fu0_ps_write,
    input  logic [c_PS_AW-1:0]         fu0_ps_addr,
    input  logic                       fu0_ps_data,

    input  logic                       fu1_valid,
    output logic                       fu1_ready,
    input  logic                       fu1_use_rw,
    input  logic [c_RW_AW-1:0]         fu1_rw_addr,
    input  logic [c_DATA_W-1:0]        fu1_rw_data,
    input  logic                       fu1_ps_write,
    input  logic [c_PS_AW-1:0]         fu1_ps_addr,
    input  logic                       fu1_ps_data,

    output logic                       write_valid,
    output logic                       use_rw,
    output logic [c_RW_AW-1:0]         rw_addr,
    output logic [c_DATA_W-1:0]        rw_data,
    output logic                       ps_write,
    output logic [c_PS_AW-1:0]         ps_addr,
    output logic                       ps_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [c_PW-1:0]   r_head;
    logic [c_PW-1:0]   r_tail;
    logic [c_CW-1:0]   r_count;

    logic [c_CW-1:0]   w_free;
    logic              w_nonempty;
    logic              w_st0;
    logic              w_st1;
    logic [c_PW-1:0]   w_tail1;
    wb_entry_t         w_e0;
    wb_entry_t         w_e1;
    wb_entry_t         w_head;

    assign w_e0 = '{fu0_use_rw, fu0_rw_addr, fu0_rw_data, fu0_ps_write, fu0_ps_addr, fu0_ps_data};
    assign w_e1 = '{fu1_use_rw, fu1_rw_addr, fu1_rw_data, fu1_ps_write, fu1_ps_addr, fu1_ps_data};

    // Free space from registered occupancy only; the same-cycle dequeue is not
    // credited, which keeps ready off the drain path. rst gating keeps both
    // readies low while the queue is held in reset.
    assign w_free     = c_CW'(DEPTH) - r_count;
    assign w_nonempty = (r_count != '0);

    assign fu0_ready = (w_free >= c_CW'(1)) & ~flush & ~rst;
    assign fu1_ready = ((w_free >= c_CW'(2)) | ((w_free >= c_CW'(1)) & ~fu0_valid))
                       & ~flush & ~rst;

    // Null results handshake normally but never occupy a slot.
    assign w_st0 = fu0_valid & fu0_ready & wb_has_work(fu0_use_rw, fu0_ps_write);
    assign w_st1 = fu1_valid & fu1_ready & wb_has_work(fu1_use_rw, fu1_ps_write);

    // fu1 lands behind fu0 only when fu0 actually stored this cycle.
    assign w_tail1 = r_tail + c_PW'(w_st0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_st0) begin
                r_mem[r_tail] <= w_e0;
            end
            if (w_st1) begin
                r_mem[w_tail1] <= w_e1;
            end
            r_tail  <= r_tail + c_PW'(w_st0) + c_PW'(w_st1);
            r_head  <= r_head + c_PW'(w_nonempty);
            r_count <= r_count + c_CW'(w_st0) + c_CW'(w_st1) - c_CW'(w_nonempty);
        end
    end

    // Head fields are forced to zero when empty so stale slots never leak out.
    assign w_head      = w_nonempty ? r_mem[r_head] : '0;
    assign write_valid = w_nonempty;
    assign {use_rw, rw_addr, rw_data, ps_write, ps_addr, ps_data} = w_head;
    assign count       = r_count;

endmodule : writeback_queue

`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_queue
// Description : Self-checking bench for writeback_queue. Random producer
//               traffic is checked every cycle against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_queue;
    import writeback_queue_pkg::*;

    localparam int c_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic fu0_valid = 0, fu0_use_rw = 0, fu0_ps_write = 0, fu0_ps_data = 0;
    logic [c_RW_AW-1:0]  fu0_rw_addr = '0;
    logic [c_DATA_W-1:0] fu0_rw_data = '0;
    logic [c_PS_AW-1:0]  fu0_ps_addr = '0;
    logic fu1_valid = 0, fu1_use_rw = 0, fu1_ps_write = 0, fu1_ps_data = 0;
    logic [c_RW_AW-1:0]  fu1_rw_addr = '0;
    logic [c_DATA_W-1:0] fu1_rw_data = '0;
    logic [c_PS_AW-1:0]  fu1_ps_addr = '0;

    logic fu0_ready, fu1_ready, write_valid, use_rw, ps_write, ps_data;
    logic [c_RW_AW-1:0]  rw_addr;
    logic [c_DATA_W-1:0] rw_data;
    logic [c_PS_AW-1:0]  ps_addr;
    logic [$clog2(c_DEPTH):0] count;

    writeback_queue #(.DEPTH(c_DEPTH)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu0_valid(fu0_valid), .fu0_ready(fu0_ready), .fu0_use_rw(fu0_use_rw),
        .fu0_rw_addr(fu0_rw_addr), .fu0_rw_data(fu0_rw_data), .fu0_ps_write(fu0_ps_write),
        .fu0_ps_addr(fu0_ps_addr), .fu0_ps_data(fu0_ps_data),
        .fu1_valid(fu1_valid), .fu1_ready(fu1_ready), .fu1_use_rw(fu1_use_rw),
        .fu1_rw_addr(fu1_rw_addr), .fu1_rw_data(fu1_rw_data), .fu1_ps_write(fu1_ps_write),
        .fu1_ps_addr(fu1_ps_addr), .fu1_ps_data(fu1_ps_data),
        .write_valid(write_valid), .use_rw(use_rw), .rw_addr(rw_addr), .rw_data(rw_data),
        .ps_write(ps_write), .ps_addr(ps_addr), .ps_data(ps_data), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    wb_entry_t mq [$];   // reference model: entries in drain order

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic wb_entry_t dut_head();
        return '{use_rw, rw_addr, rw_data, ps_write, ps_addr, ps_data};
    endfunction

    // Drive one producer: null selects a result that writes nothing.
    task automatic drive(input int n, input bit v, input bit nul);
        logic u, p;
        u = nul ? 1'b0 : 1'($urandom_range(0, 1));
        p = nul ? 1'b0 : (u ? 1'($urandom_range(0, 1)) : 1'b1);
        if (n == 0) begin
            fu0_valid = v; fu0_use_rw = u; fu0_ps_write = p;
            fu0_rw_addr = c_RW_AW'($urandom); fu0_rw_data = c_DATA_W'($urandom);
            fu0_ps_addr = c_PS_AW'($urandom); fu0_ps_data = 1'($urandom);
        end else begin
            fu1_valid = v; fu1_use_rw = u; fu1_ps_write = p;
            fu1_rw_addr = c_RW_AW'($urandom); fu1_rw_data = c_DATA_W'($urandom);
            fu1_ps_addr = c_PS_AW'($urandom); fu1_ps_data = 1'($urandom);
        end
    endtask

    task automatic idle();
        fu0_valid = 0; fu1_valid = 0; flush = 0;
    endtask

    // Check the cycle at the falling edge, then advance the model at the rising edge.
    task automatic do_cycle();
        int        fr;
        bit        r0, r1, a0, a1, f;
        wb_entry_t e0, e1;
        @(negedge clk);
        fr = c_DEPTH - mq.size();
        f  = flush;
        r0 = (fr >= 1) && !f;
        r1 = ((fr >= 2) || (fr >= 1 && !fu0_valid)) && !f;
        chk("fu0_ready", 64'(fu0_ready), 64'(r0));
        chk("fu1_ready", 64'(fu1_ready), 64'(r1));
        chk("count", 64'(count), 64'(mq.size()));
        chk("write_valid", 64'(write_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) chk("head", 64'(dut_head()), 64'(mq[0]));
        else               chk("head_idle", 64'(dut_head()), 64'(0));
        a0 = fu0_valid && r0 && (fu0_use_rw || fu0_ps_write);
        a1 = fu1_valid && r1 && (fu1_use_rw || fu1_ps_write);
        e0 = '{fu0_use_rw, fu0_rw_addr, fu0_rw_data, fu0_ps_write, fu0_ps_addr, fu0_ps_data};
        e1 = '{fu1_use_rw, fu1_rw_addr, fu1_rw_data, fu1_ps_write, fu1_ps_addr, fu1_ps_data};
        @(posedge clk);
        if (mq.size() > 0) void'(mq.pop_front());
        if (f) mq.delete();
        else begin
            if (a0) mq.push_back(e0);
            if (a1) mq.push_back(e1);
        end
        #1;
    endtask

    initial begin
        // Reset state while rst is held.
        #2;
        chk("rst_fu0_ready", 64'(fu0_ready), 64'(0));
        chk("rst_fu1_ready", 64'(fu1_ready), 64'(0));
        chk("rst_write_valid", 64'(write_valid), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_head", 64'(dut_head()), 64'(0));
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Single fu0 result to r3 = 0x5A.
        idle();
        fu0_valid = 1; fu0_use_rw = 1; fu0_rw_addr = 3; fu0_rw_data = c_DATA_W'(32'h5A);
        fu0_ps_write = 0; fu0_ps_addr = '0; fu0_ps_data = 0;
        do_cycle();
        idle();
        @(negedge clk);
        chk("single_valid", 64'(write_valid), 64'(1));
        chk("single_addr", 64'(rw_addr), 64'(3));
        chk("single_data", 64'(rw_data), 64'(32'h5A));
        @(posedge clk); #1;
        void'(mq.pop_front());
        do_cycle();   // model confirms write_valid dropped after one cycle

        // Saturating traffic: both producers every cycle.
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 0); drive(1, 1, 0); do_cycle();
        end
        // Only fu1 while nearly full, then null on fu1 alongside fu0.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0); drive(1, 1, 0); do_cycle();
        end
        idle(); for (int i = 0; i < 5; i++) do_cycle();
        drive(0, 1, 0); drive(1, 1, 1); do_cycle();
        idle(); for (int i = 0; i < 3; i++) do_cycle();

        // Build three entries, then flush for one cycle.
        drive(0, 1, 0); drive(1, 1, 0); do_cycle();
        drive(0, 1, 0); drive(1, 1, 0); do_cycle();
        idle(); chk("pre_flush_count", 64'(count), 64'(3));
        drive(0, 1, 0); drive(1, 1, 0); flush = 1; do_cycle();
        idle(); do_cycle();

        // Randomized traffic with varying density, nulls and occasional flush.
        for (int i = 0; i < 2000; i++) begin
            int dens;
            dens = (i / 200) % 4;
            drive(0, ($urandom_range(0, 3) < dens + 1), ($urandom_range(0, 4) == 0));
            drive(1, ($urandom_range(0, 3) < dens + 1), ($urandom_range(0, 4) == 0));
            flush = ($urandom_range(0, 39) == 0);
            do_cycle();
        end
        idle();

        // Asynchronous reset between edges with two entries queued.
        drive(0, 1, 0); drive(1, 1, 0); do_cycle();
        idle();
        #2 rst = 1;
        #1;
        chk("arst_write_valid", 64'(write_valid), 64'(0));
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_fu0_ready", 64'(fu0_ready), 64'(0));
        chk("arst_head", 64'(dut_head()), 64'(0));
        mq.delete();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) do_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_writeback_queue

`default_nettype wire
